// File: rtl/prio_enc_n.sv
`timescale 1ns/1ps
// prio_enc_n: registered N-input priority encoder with valid/ready on both sides.
// Picks one active request by highest-index, lowest-index or round-robin priority
// and holds the index, one-hot grant and "any active" flag until consumed.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   mode         00 highest, 01 lowest, 10 round-robin, 11 same as 00
//   req_valid    request vector valid
//   req_ready    block can accept this cycle (combinational)
//   req          N-bit request vector
//   out_valid    result registers hold an unconsumed result
//   out_ready    consumer takes the result this cycle
//   idx          granted index
//   onehot       one-hot grant (zero when nothing requested)
//   any          at least one request bit was set
module prio_enc_n #(
    parameter  int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   mode,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         any
);

    localparam logic [1:0] MODE_LOW = 2'b01;
    localparam logic [1:0] MODE_RR  = 2'b10;

    logic [W-1:0] ptr;
    logic [W-1:0] hi_sel;
    logic [W-1:0] lo_sel;
    logic [W-1:0] rr_sel;
    logic         rr_found;
    logic [W-1:0] sel;
    logic         any_nxt;
    logic         accept;

    // Single output stage: free when empty or being drained this cycle.
    assign req_ready = !out_valid || out_ready;
    assign accept    = req_valid && req_ready;
    assign any_nxt   = |req;

    // Highest and lowest set bit; later loop assignments take precedence.
    always_comb begin
        hi_sel = '0;
        lo_sel = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (req[i]) hi_sel = W'(i);
        end
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) lo_sel = W'(i);
        end
    end

    // Round-robin: lowest set bit at or above ptr, otherwise wrap to lowest overall.
    always_comb begin
        rr_sel   = '0;
        rr_found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (req[i] && (W'(i) >= ptr) && !rr_found) begin
                rr_sel   = W'(i);
                rr_found = 1'b1;
            end
        end
        if (!rr_found) rr_sel = lo_sel;
    end

    // Mode select; reserved mode 11 falls through to highest-index.
    always_comb begin
        sel = hi_sel;
        case (mode)
            MODE_LOW: sel = lo_sel;
            MODE_RR:  sel = rr_sel;
            default:  sel = hi_sel;
        endcase
    end

    // Result registers and out_valid tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            idx       <= '0;
            onehot    <= '0;
            any       <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            idx       <= any_nxt ? sel : '0;
            onehot    <= any_nxt ? (N'(1) << sel) : '0;
            any       <= any_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin pointer advances past the grant only on non-empty RR accepts;
    // explicit wrap keeps it below N for non-power-of-two sizes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && (mode == MODE_RR) && any_nxt) begin
            ptr <= (sel == W'(N - 1)) ? '0 : sel + W'(1);
        end
    end

endmodule
